// File: rtl/causal_ctx_gen_if.sv
// ---------------------------------------------------------------------------
// causal_ctx_gen_if
//
// Bundles the pixel input stream, the context output stream and the frame
// control/status lines of causal_ctx_gen.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid must
// keep its payload stable until that edge. Ready may depend on valid in the
// same cycle.
//
// Signals:
//   start                    frame arm request (honoured only when idle)
//   pix_in/pix_valid/pix_ready  incoming raster-order samples
//   ctx_valid/ctx_ready      context stream handshake
//   a, b, c, d, x            left, above, above-left, above-right, current
//   col_index, row_index     position of the presented context
//   EOL, EOF                 last context of line / of frame
//   busy                     frame in progress
//
// Modports:
//   master : image source plus downstream consumer (drives pixels, start and
//            ctx_ready)
//   slave  : the context generator itself
// ---------------------------------------------------------------------------
interface causal_ctx_gen_if #(
    parameter int pixel_length = 8,
    parameter int COL_BITS     = 8,
    parameter int ROW_BITS     = 9
);
    logic                    start;
    logic [pixel_length-1:0] pix_in;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    ctx_valid;
    logic                    ctx_ready;
    logic [pixel_length-1:0] a;
    logic [pixel_length-1:0] b;
    logic [pixel_length-1:0] c;
    logic [pixel_length-1:0] d;
    logic [pixel_length-1:0] x;
    logic [COL_BITS-1:0]     col_index;
    logic [ROW_BITS-1:0]     row_index;
    logic                    EOL;
    logic                    EOF;
    logic                    busy;

    modport master (
        output start, pix_in, pix_valid, ctx_ready,
        input  pix_ready, ctx_valid, a, b, c, d, x,
        input  col_index, row_index, EOL, EOF, busy
    );

    modport slave (
        input  start, pix_in, pix_valid, ctx_ready,
        output pix_ready, ctx_valid, a, b, c, d, x,
        output col_index, row_index, EOL, EOF, busy
    );
endinterface

// File: rtl/causal_ctx_gen.sv
// ---------------------------------------------------------------------------
// causal_ctx_gen
//
// Streaming JPEG-LS causal-template generator. Raster-order pixels arrive on
// the pixel stream; the previous line is kept in an internal line buffer and
// one context (a, b, c, d, x) is emitted per pixel with the JPEG-LS edge rules:
//   row 0        : b = c = d = 0, a = previous x (0 at column 0)
//   row>0, col 0 : a = b, c = Ra used at column 0 of the previous line
//   row>0, col>0 : a = previous x, c = previous b
//   last column  : d = b
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   bus      causal_ctx_gen_if.slave (pixel stream, context stream, start,
//            busy, position and EOL/EOF flags)
//   state_o  FSM state (0 IDLE, 1 RUN, 2 FLUSH) for observation
//
// Build option: define CTX_SKID_EN to add a one-entry skid register so that
// pix_ready is a flop with no combinational path from ctx_ready. Without it,
// pix_ready = RUN && (!ctx_valid || ctx_ready). Context streams are identical
// in both builds.
// ---------------------------------------------------------------------------
module causal_ctx_gen #(
    parameter int pixel_length = 8,
    parameter int LINE_WIDTH   = 135,
    parameter int NUM_LINES    = 311,
    parameter int COL_BITS     = $clog2(LINE_WIDTH + 1),
    parameter int ROW_BITS     = $clog2(NUM_LINES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    causal_ctx_gen_if.slave       bus,
    output logic [1:0]            state_o
);
    localparam int PW       = pixel_length;
    localparam int IDX_BITS = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LINE_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [PW-1:0]       a;
        logic [PW-1:0]       b;
        logic [PW-1:0]       c;
        logic [PW-1:0]       d;
        logic [PW-1:0]       x;
        logic [COL_BITS-1:0] col;
        logic [ROW_BITS-1:0] row;
        logic                eol;
        logic                eof;
    } ctx_t;

    state_t              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PW-1:0]       ra_first_q, ra_first_d;
    logic [PW-1:0]       prev_x_q, prev_x_d;
    logic [PW-1:0]       prev_b_q, prev_b_d;
    ctx_t                out_q, out_d;
    logic                ctx_valid_q, ctx_valid_d;
    logic [PW-1:0]       lb_q [LINE_WIDTH];

    logic                pix_ready;
    logic                accept;
    logic                ctx_take;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] nxt_idx;
    logic [PW-1:0]       lb_b;
    logic [PW-1:0]       lb_d;
    ctx_t                new_ctx;

`ifdef CTX_SKID_EN
    ctx_t skid_q, skid_d;
    logic skid_valid_q, skid_valid_d;
    logic pix_ready_q, pix_ready_d;

    assign pix_ready = pix_ready_q;
`else
    assign pix_ready = (state_q == RUN) && (!ctx_valid_q || bus.ctx_ready);
`endif

    assign accept   = bus.pix_valid && pix_ready;
    assign ctx_take = ctx_valid_q && bus.ctx_ready;

    // Line-buffer read happens before the same-cycle write. At the last
    // column the above-right neighbour does not exist, so d repeats b.
    assign rd_idx  = col_q[IDX_BITS-1:0];
    assign nxt_idx = (col_q == LAST_COL) ? rd_idx : rd_idx + IDX_BITS'(1);
    assign lb_b    = lb_q[rd_idx];
    assign lb_d    = lb_q[nxt_idx];

    // Context for the pixel currently on pix_in.
    always_comb begin
        new_ctx     = '0;
        new_ctx.x   = bus.pix_in;
        new_ctx.col = col_q;
        new_ctx.row = row_q;
        new_ctx.eol = (col_q == LAST_COL);
        new_ctx.eof = (col_q == LAST_COL) && (row_q == LAST_ROW);
        if (row_q == '0) begin
            new_ctx.a = (col_q == '0) ? '0 : prev_x_q;
        end else if (col_q == '0) begin
            new_ctx.a = lb_b;
            new_ctx.b = lb_b;
            new_ctx.c = ra_first_q;
            new_ctx.d = lb_d;
        end else begin
            new_ctx.a = prev_x_q;
            new_ctx.b = lb_b;
            new_ctx.c = prev_b_q;
            new_ctx.d = lb_d;
        end
    end

    // Next-state: FSM, position counters, neighbour history, output stage.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ra_first_d  = ra_first_q;
        prev_x_d    = prev_x_q;
        prev_b_d    = prev_b_q;
        out_d       = out_q;
        ctx_valid_d = ctx_valid_q;
`ifdef CTX_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        pix_ready_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    col_d      = '0;
                    row_d      = '0;
                    ra_first_d = '0;
                end
            end
            RUN: begin
                if (accept && new_ctx.eof) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (ctx_take && out_q.eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            prev_x_d = bus.pix_in;
            prev_b_d = new_ctx.b;
            if ((row_q != '0) && (col_q == '0)) begin
                ra_first_d = new_ctx.a;
            end
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_BITS'(1);
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end

`ifdef CTX_SKID_EN
        // Output register refills from the skid entry first so ordering is
        // preserved; a context accepted during a stall parks in the skid.
        if (!ctx_valid_q || bus.ctx_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                ctx_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_ctx;
                ctx_valid_d = 1'b1;
            end else begin
                ctx_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_ctx;
            skid_valid_d = 1'b1;
        end
        pix_ready_d = (state_d == RUN) && !skid_valid_d;
`else
        if (accept) begin
            out_d       = new_ctx;
            ctx_valid_d = 1'b1;
        end else if (ctx_take) begin
            ctx_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            ra_first_q  <= '0;
            prev_x_q    <= '0;
            prev_b_q    <= '0;
            out_q       <= '0;
            ctx_valid_q <= 1'b0;
`ifdef CTX_SKID_EN
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            pix_ready_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ra_first_q  <= ra_first_d;
            prev_x_q    <= prev_x_d;
            prev_b_q    <= prev_b_d;
            out_q       <= out_d;
            ctx_valid_q <= ctx_valid_d;
`ifdef CTX_SKID_EN
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            pix_ready_q  <= pix_ready_d;
`endif
        end
    end

    // Line buffer holds no reset: row 0 forces b, c, d to zero, so stale
    // contents from a previous frame are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[rd_idx] <= bus.pix_in;
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.ctx_valid = ctx_valid_q;
    assign bus.a         = out_q.a;
    assign bus.b         = out_q.b;
    assign bus.c         = out_q.c;
    assign bus.d         = out_q.d;
    assign bus.x         = out_q.x;
    assign bus.col_index = out_q.col;
    assign bus.row_index = out_q.row;
    assign bus.EOL       = out_q.eol;
    assign bus.EOF       = out_q.eof;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;

endmodule
